regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_write_arbiter.sv | 90 +++++++++
 tb/tb_regfile_write_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port between NUM_REQ requesters.
// Define REGFILE_ARB_LOCK_EN to add req_lock, which keeps top priority on the accepted requester.
module regfile_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef REGFILE_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_lock,
`endif
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          wr_en,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [$clog2(NUM_REQ)-1:0]    wr_grant_id,
    input  logic                          wr_ready
);
    localparam int ID_WIDTH = $clog2(NUM_REQ);
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] rr_ptr_next;
    logic [ID_WIDTH-1:0] grant_id;
    logic                grant_found;
    logic                stage_free;
    logic                transfer;

    // A retiring write frees the stage in the same cycle, giving back-to-back throughput.
    assign stage_free = !wr_en || wr_ready;

    always_comb begin : rr_scan
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_found && req_valid[ID_WIDTH'(idx)]) begin
                grant_found = 1'b1;
                grant_id    = ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin : ready_gen
        req_ready = '0;
        if (reset_n && stage_free && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign transfer = |(req_valid & req_ready);

    always_comb begin : ptr_next
        rr_ptr_next = (grant_id == LAST_ID) ? '0 : grant_id + ID_WIDTH'(1);
`ifdef REGFILE_ARB_LOCK_EN
        // A locked winner stays at the head of the scan for its follow-up write.
        if (req_lock[grant_id]) begin
            rr_ptr_next = grant_id;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_grant_id <= '0;
            rr_ptr      <= '0;
        end else if (transfer) begin
            wr_en       <= 1'b1;
            wr_addr     <= req_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
            wr_data     <= req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
            wr_grant_id <= grant_id;
            rr_ptr      <= rr_ptr_next;
        end else if (wr_en && wr_ready) begin
            wr_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: stimulus pushes expected writes, a monitor checks retirements.
module tb_regfile_write_arbiter;

    typedef struct {
        logic [1:0]  id;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_exp_t;

    logic         clk;
    logic         reset_n;
    logic [3:0]   req_valid;
    logic [19:0]  req_addr;
    logic [127:0] req_data;
    logic [3:0]   req_lock;
    logic [3:0]   req_ready;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;
    logic [1:0]   wr_grant_id;
    logic         wr_ready;

    int      checks;
    int      errors;
    wr_exp_t exp_q[$];
    wr_exp_t mon_exp;

    regfile_write_arbiter #(
        .NUM_REQ   (4),
        .ADDR_WIDTH(5),
        .DATA_WIDTH(32)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
`ifdef REGFILE_ARB_LOCK_EN
        .req_lock   (req_lock),
`endif
        .req_ready  (req_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_grant_id(wr_grant_id),
        .wr_ready   (wr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[i*5 +: 5]  = a;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic rdy);
        req_valid = v;
        wr_ready  = rdy;
    endtask

    task automatic expectWrite(input int id, input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back('{id: 2'(id), addr: a, data: d});
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every retiring write must match the oldest expected write, in order.
    always @(negedge clk) begin
        if (reset_n && wr_en && wr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write got id=%0d addr=%0d data=%h expected none",
                         wr_grant_id, wr_addr, wr_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (wr_grant_id !== mon_exp.id || wr_addr !== mon_exp.addr || wr_data !== mon_exp.data) begin
                    errors++;
                    $display("[TB] FAIL write_port got id=%0d addr=%0d data=%h expected id=%0d addr=%0d data=%h",
                             wr_grant_id, wr_addr, wr_data, mon_exp.id, mon_exp.addr, mon_exp.data);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] exp_rdy;
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        req_lock  = '0;
        wr_ready  = 1'b0;

        #1 reset_n = 1'b0;
        #2;
        checkOutput("reset_wr_en", 64'(wr_en), 64'd0);
        checkOutput("reset_wr_addr", 64'(wr_addr), 64'd0);
        checkOutput("reset_wr_data", 64'(wr_data), 64'd0);
        checkOutput("reset_grant_id", 64'(wr_grant_id), 64'd0);
        checkOutput("reset_ready_idle", 64'(req_ready), 64'd0);
        applyStimulus(4'b1111, 1'b1);
        #1;
        checkOutput("reset_ready_gated", 64'(req_ready), 64'd0);
        #3 applyStimulus(4'b0000, 1'b0);
        #5 reset_n = 1'b1;
        cycle();

        // Single write from requester 2, one-cycle latency.
        setReq(2, 5'd3, 32'hDEADBEEF);
        applyStimulus(4'b0100, 1'b1);
        expectWrite(2, 5'd3, 32'hDEADBEEF);
        #1;
        checkOutput("first_ready", 64'(req_ready), 64'(4'b0100));
        cycle();
        checkOutput("first_wr_en", 64'(wr_en), 64'd1);
        checkOutput("first_wr_addr", 64'(wr_addr), 64'd3);
        checkOutput("first_wr_data", 64'(wr_data), 64'hDEADBEEF);
        checkOutput("first_grant_id", 64'(wr_grant_id), 64'd2);
        applyStimulus(4'b0000, 1'b1);
        cycle();
        checkOutput("retire_wr_en", 64'(wr_en), 64'd0);
        checkOutput("retire_addr_held", 64'(wr_addr), 64'd3);
        checkOutput("retire_id_held", 64'(wr_grant_id), 64'd2);

        // Pointer sits at 3: requester 0 wins by wrap, then requester 2.
        setReq(0, 5'd10, 32'hA0A0A0A0);
        setReq(2, 5'd12, 32'hA2A2A2A2);
        applyStimulus(4'b0101, 1'b1);
        expectWrite(0, 5'd10, 32'hA0A0A0A0);
        #1;
        checkOutput("wrap_ready_0", 64'(req_ready), 64'(4'b0001));
        cycle();
        expectWrite(2, 5'd12, 32'hA2A2A2A2);
        #1;
        checkOutput("wrap_ready_2", 64'(req_ready), 64'(4'b0100));
        cycle();

        // Requester 3 moves the pointer back to 0.
        setReq(3, 5'd7, 32'h33333333);
        applyStimulus(4'b1000, 1'b1);
        expectWrite(3, 5'd7, 32'h33333333);
        #1;
        checkOutput("align_ready_3", 64'(req_ready), 64'(4'b1000));
        cycle();

        // All four valid: strict rotation with no bubbles.
        for (int i = 0; i < 4; i++) begin
            setReq(i, 5'(16 + i), 32'(32'hC0DE0000 + i));
        end
        applyStimulus(4'b1111, 1'b1);
        for (int k = 0; k < 8; k++) begin
            checkOutput("rr_wr_en_continuous", 64'(wr_en), 64'd1);
            expectWrite(k % 4, 5'(16 + k % 4), 32'(32'hC0DE0000 + k % 4));
            exp_rdy = 4'b0001 << (k % 4);
            #1;
            checkOutput("rr_ready", 64'(req_ready), 64'(exp_rdy));
            cycle();
        end

        // Stall with requester 3's write pending.
        setReq(0, 5'd20, 32'hAAAA0000);
        setReq(1, 5'd21, 32'hBBBB0001);
        applyStimulus(4'b0011, 1'b0);
        for (int s = 0; s < 3; s++) begin
            #1;
            checkOutput("stall_ready", 64'(req_ready), 64'd0);
            checkOutput("stall_wr_en", 64'(wr_en), 64'd1);
            checkOutput("stall_wr_addr", 64'(wr_addr), 64'd19);
            checkOutput("stall_wr_data", 64'(wr_data), 64'hC0DE0003);
            checkOutput("stall_grant_id", 64'(wr_grant_id), 64'd3);
            cycle();
        end
        applyStimulus(4'b0011, 1'b1);
        expectWrite(0, 5'd20, 32'hAAAA0000);
        #1;
        checkOutput("unstall_ready", 64'(req_ready), 64'(4'b0001));
        cycle();
        checkOutput("unstall_no_bubble", 64'(wr_en), 64'd1);
        checkOutput("unstall_wr_addr", 64'(wr_addr), 64'd20);
        applyStimulus(4'b0010, 1'b1);
        expectWrite(1, 5'd21, 32'hBBBB0001);
        #1;
        checkOutput("unstall_ready_1", 64'(req_ready), 64'(4'b0010));
        cycle();

        // Load a write, hold it, then reset: it must vanish immediately.
        setReq(0, 5'd9, 32'h12345678);
        applyStimulus(4'b0001, 1'b1);
        #1;
        checkOutput("pre_reset_ready", 64'(req_ready), 64'(4'b0001));
        cycle();
        applyStimulus(4'b0000, 1'b0);
        checkOutput("pre_reset_wr_en", 64'(wr_en), 64'd1);
        checkOutput("pre_reset_wr_data", 64'(wr_data), 64'h12345678);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_reset_wr_en", 64'(wr_en), 64'd0);
        checkOutput("async_reset_wr_data", 64'(wr_data), 64'd0);
        checkOutput("async_reset_wr_addr", 64'(wr_addr), 64'd0);
        checkOutput("async_reset_grant_id", 64'(wr_grant_id), 64'd0);
        #3 reset_n = 1'b1;
        cycle();
        setReq(1, 5'd2, 32'h0BAD0001);
        setReq(3, 5'd3, 32'h0BAD0003);
        applyStimulus(4'b1010, 1'b1);
        expectWrite(1, 5'd2, 32'h0BAD0001);
        #1;
        checkOutput("post_reset_ready", 64'(req_ready), 64'(4'b0010));
        cycle();
        checkOutput("post_reset_grant_id", 64'(wr_grant_id), 64'd1);
        applyStimulus(4'b0000, 1'b1);
        cycle();

`ifdef REGFILE_ARB_LOCK_EN
        // Locked requester 0 keeps priority for exactly one follow-up write.
        setReq(0, 5'd4, 32'h10C00000);
        setReq(1, 5'd5, 32'h10C00001);
        req_lock = 4'b0001;
        applyStimulus(4'b0011, 1'b1);
        expectWrite(0, 5'd4, 32'h10C00000);
        #1;
        checkOutput("lock_first_ready", 64'(req_ready), 64'(4'b0001));
        cycle();
        req_lock = 4'b0000;
        expectWrite(0, 5'd4, 32'h10C00000);
        #1;
        checkOutput("lock_second_ready", 64'(req_ready), 64'(4'b0001));
        cycle();
        expectWrite(1, 5'd5, 32'h10C00001);
        #1;
        checkOutput("lock_release_ready", 64'(req_ready), 64'(4'b0010));
        cycle();
        applyStimulus(4'b0000, 1'b1);
`endif

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) begin
            cycle();
        end
        checkOutput("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
